// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: grants the bus on hreqb, turns one AHB single transfer
// into one APB SETUP/ACCESS cycle and reports completion via hready_out/hresp.
// Optional macro PTIMEOUT_EN bounds the ACCESS wait to TIMEOUT cycles.
module ahb_apb_bridge #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_PSLV = 4,
  parameter int unsigned PSEL_LSB = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         hreqb,
  output logic                         hgrantb,
  input  logic                         hsel,
  input  logic [1:0]                   htrans,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic                         hwrite,
  input  logic [DATA_W-1:0]            hwdata,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready_out,
  output logic                         hresp,
  output logic [ADDR_W-1:0]            paddr,
  output logic [NUM_PSLV-1:0]          psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_PSLV*DATA_W-1:0]   prdata,
  input  logic [NUM_PSLV-1:0]          pready,
  input  logic [NUM_PSLV-1:0]          pslverr
);

  localparam int unsigned IW = $clog2(NUM_PSLV);

  typedef enum logic [2:0] {
    IDLE, GRANT, ADDR, SETUP, ACCESS, DONE, ERR1, ERR2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx;
  logic            tmo_hit;
  logic            addr_take;

  logic                hgrantb_n, hready_n, hresp_n, penable_n;
  logic [NUM_PSLV-1:0] psel_n;

  // Only the transfer-type MSB matters; NONSEQ and SEQ are treated alike.
  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  assign addr_take = (state == GRANT) && hreqb && hsel && htrans[1];

`ifdef PTIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // tmo_cnt holds the number of ACCESS cycles already elapsed; the wait ends
  // in the cycle that would make it reach TIMEOUT.
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // ACCESS-cycle counter: counts while staying in ACCESS, otherwise cleared.
  always_ff @(posedge hclk) begin
    if (hreset)                                   tmo_cnt <= '0;
    else if (state == ACCESS && state_n == ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
    else                                          tmo_cnt <= '0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  // Next state, plus next values for the registered control outputs.
  // Outputs are derived from state_n so their registers track the state.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (hreqb) state_n = GRANT;
      GRANT:  begin
        if (!hreqb)                 state_n = IDLE;
        else if (hsel && htrans[1]) state_n = ADDR;
      end
      ADDR:   state_n = SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        if (pready[idx]) state_n = pslverr[idx] ? ERR1 : DONE;
        else if (tmo_hit) state_n = ERR1;
      end
      DONE:   state_n = hreqb ? GRANT : IDLE;
      ERR1:   state_n = ERR2;
      ERR2:   state_n = hreqb ? GRANT : IDLE;
      default: state_n = IDLE;
    endcase

    hgrantb_n = (state_n != IDLE);
    penable_n = (state_n == ACCESS);
    psel_n    = (state_n == SETUP || state_n == ACCESS) ? (NUM_PSLV'(1) << idx) : '0;
    hready_n  = (state_n == DONE) || (state_n == ERR2);
    hresp_n   = (state_n == ERR1) || (state_n == ERR2);
  end

  // State and control-output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= IDLE;
      hgrantb    <= 1'b0;
      psel       <= '0;
      penable    <= 1'b0;
      hready_out <= 1'b0;
      hresp      <= 1'b0;
    end else begin
      state      <= state_n;
      hgrantb    <= hgrantb_n;
      psel       <= psel_n;
      penable    <= penable_n;
      hready_out <= hready_n;
      hresp      <= hresp_n;
    end
  end

  // Datapath: address/direction capture, write data capture, read return.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      idx    <= '0;
      pwdata <= '0;
      hrdata <= '0;
    end else begin
      if (addr_take) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        idx    <= haddr[PSEL_LSB +: IW];
      end
      if (state == ADDR)
        pwdata <= hwdata;
      if (state == ACCESS && pready[idx] && !pslverr[idx] && !pwrite)
        hrdata <= prdata[idx*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge (NUM_PSLV=4, TIMEOUT=4).
module tb_ahb_apb_bridge;

  logic         hclk = 1'b0;
  logic         hreset, hreqb, hsel, hwrite;
  logic [1:0]   htrans;
  logic [31:0]  haddr, hwdata, hrdata, paddr, pwdata;
  logic         hgrantb, hready_out, hresp, penable, pwrite;
  logic [3:0]   psel, pready, pslverr;
  logic [127:0] prdata;

  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  ahb_apb_bridge #(
    .ADDR_W(32), .DATA_W(32), .NUM_PSLV(4), .PSEL_LSB(12), .TIMEOUT(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hreqb(hreqb), .hgrantb(hgrantb),
    .hsel(hsel), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(hrdata), .hready_out(hready_out), .hresp(hresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // From GRANT: address phase, then data phase; returns with the DUT in SETUP.
  task automatic start_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    haddr = a; hwrite = w; hsel = 1'b1; htrans = 2'b10;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = d;
    tick();
    hwdata = 32'h0;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hreqb = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0;
    hwrite = 1'b0; hwdata = '0; pready = '0; pslverr = '0; prdata = '0;
    tick(); tick();
    checks++; if (hgrantb !== 1'b0) begin errors++; $display("FAIL rst_hgrantb: got %b want 0", hgrantb); end
    checks++; if (hready_out !== 1'b0) begin errors++; $display("FAIL rst_hready: got %b want 0", hready_out); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp: got %b want 0", hresp); end
    checks++; if ({psel, penable} !== 5'b0) begin errors++; $display("FAIL rst_apb: got %b want 00000", {psel, penable}); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h want 0", hrdata); end
    hreset = 1'b0;
    tick();
    checks++; if (hgrantb !== 1'b0) begin errors++; $display("FAIL idle_hgrantb: got %b want 0", hgrantb); end
  endtask

  task automatic test_write_nowait();
    hreqb = 1'b1;
    tick();
    checks++; if (hgrantb !== 1'b1) begin errors++; $display("FAIL wr_grant: got %b want 1", hgrantb); end
    pready = 4'b0100;
    haddr = 32'h0000_2010; hwrite = 1'b1; hsel = 1'b1; htrans = 2'b10;
    tick();
    checks++; if (psel !== 4'b0000) begin errors++; $display("FAIL wr_addr_psel: got %b want 0000", psel); end
    checks++; if (paddr !== 32'h0000_2010) begin errors++; $display("FAIL wr_paddr: got %h want 00002010", paddr); end
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    tick();
    hwdata = 32'h0;
    checks++; if (psel !== 4'b0100 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup: got psel=%b pen=%b want 0100/0", psel, penable); end
    checks++; if (pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1) begin errors++; $display("FAIL wr_pwdata: got %h/%b want deadbeef/1", pwdata, pwrite); end
    tick();
    checks++; if (psel !== 4'b0100 || penable !== 1'b1 || hready_out !== 1'b0) begin errors++; $display("FAIL wr_access: got psel=%b pen=%b rdy=%b want 0100/1/0", psel, penable, hready_out); end
    tick();
    checks++; if (hready_out !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL wr_done: got rdy=%b resp=%b want 1/0", hready_out, hresp); end
    checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin errors++; $display("FAIL wr_done_apb: got psel=%b pen=%b want 0000/0", psel, penable); end
    tick();
    checks++; if (hready_out !== 1'b0 || hgrantb !== 1'b1) begin errors++; $display("FAIL wr_after: got rdy=%b gnt=%b want 0/1", hready_out, hgrantb); end
    pready = '0;
  endtask

  task automatic test_read_wait();
    prdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0000};
    pready = 4'b0001;  // another peripheral ready; must be ignored
    start_xfer(32'h0000_1004, 1'b0, 32'h0);
    checks++; if (psel !== 4'b0010) begin errors++; $display("FAIL rd_setup_psel: got %b want 0010", psel); end
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (penable !== 1'b1 || hready_out !== 1'b0) begin errors++; $display("FAIL rd_wait%0d: got pen=%b rdy=%b want 1/0", i, penable, hready_out); end
    end
    pready = 4'b0010;
    tick();
    checks++; if (hready_out !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL rd_done: got rdy=%b resp=%b want 1/0", hready_out, hresp); end
    checks++; if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hrdata: got %h want 12345678", hrdata); end
    pready = '0;
    tick();
    prdata = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    pready = 4'b1000;
    start_xfer(32'h0000_3000, 1'b1, 32'hCAFE_F00D);
    checks++; if (psel !== 4'b1000) begin errors++; $display("FAIL wr2_setup_psel: got %b want 1000", psel); end
    tick(); tick();
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL wr2_done: got %b want 1", hready_out); end
    checks++; if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL wr2_hrdata_hold: got %h want 12345678", hrdata); end
    checks++; if (pwdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr2_pwdata: got %h want cafef00d", pwdata); end
    pready = '0;
    tick();
  endtask

  task automatic test_slave_error();
    prdata = {32'h0, 32'h0, 32'h0, 32'hBAD0_BAD0};
    pready = 4'b0001; pslverr = 4'b0001;
    start_xfer(32'h0000_0040, 1'b0, 32'h0);
    tick();
    tick();
    checks++; if (hresp !== 1'b1 || hready_out !== 1'b0) begin errors++; $display("FAIL err1: got resp=%b rdy=%b want 1/0", hresp, hready_out); end
    checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin errors++; $display("FAIL err1_apb: got psel=%b pen=%b want 0000/0", psel, penable); end
    tick();
    checks++; if (hresp !== 1'b1 || hready_out !== 1'b1) begin errors++; $display("FAIL err2: got resp=%b rdy=%b want 1/1", hresp, hready_out); end
    tick();
    checks++; if (hgrantb !== 1'b1 || hresp !== 1'b0 || hready_out !== 1'b0) begin errors++; $display("FAIL err_regrant: got gnt=%b resp=%b rdy=%b want 1/0/0", hgrantb, hresp, hready_out); end
    checks++; if (hrdata !== 32'h1234_5678) begin errors++; $display("FAIL err_hrdata_hold: got %h want 12345678", hrdata); end
    pready = '0; pslverr = '0;
  endtask

  task automatic test_back_to_back();
    pready = 4'b1111;
    start_xfer(32'h0000_2000, 1'b1, 32'h1);
    tick(); tick();
    checks++; if (hready_out !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b want 1", hready_out); end
    tick();
    checks++; if (hgrantb !== 1'b1) begin errors++; $display("FAIL b2b_nogap: got %b want 1", hgrantb); end
    haddr = 32'h0000_3008; hwrite = 1'b1; hsel = 1'b1; htrans = 2'b10;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h2;
    hreqb = 1'b0;  // request withdrawn mid-transfer; transfer must still finish
    tick();
    checks++; if (psel !== 4'b1000) begin errors++; $display("FAIL b2b_setup2: got %b want 1000", psel); end
    tick();
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL b2b_access2: got %b want 1", penable); end
    tick();
    checks++; if (hready_out !== 1'b1 || hgrantb !== 1'b1 || pwdata !== 32'h2) begin errors++; $display("FAIL b2b_done2: got rdy=%b gnt=%b pwdata=%h want 1/1/2", hready_out, hgrantb, pwdata); end
    tick();
    checks++; if (hgrantb !== 1'b0 || hready_out !== 1'b0) begin errors++; $display("FAIL b2b_release: got gnt=%b rdy=%b want 0/0", hgrantb, hready_out); end
    pready = '0;
  endtask

  task automatic test_grant_hold();
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_1000;
    tick();
    checks++; if (hgrantb !== 1'b0 || psel !== 4'b0) begin errors++; $display("FAIL idle_ignore: got gnt=%b psel=%b want 0/0000", hgrantb, psel); end
    htrans = 2'b00; hreqb = 1'b1;
    tick();
    htrans = 2'b01;
    tick();
    htrans = 2'b00;
    tick();
    checks++; if (hgrantb !== 1'b1 || psel !== 4'b0 || hready_out !== 1'b0) begin errors++; $display("FAIL grant_hold: got gnt=%b psel=%b rdy=%b want 1/0000/0", hgrantb, psel, hready_out); end
    hsel = 1'b0; hreqb = 1'b0;
    tick();
    checks++; if (hgrantb !== 1'b0) begin errors++; $display("FAIL grant_drop: got %b want 0", hgrantb); end
  endtask

  task automatic test_reset_mid_access();
    hreqb = 1'b1; pready = '0;
    tick();
    start_xfer(32'h0000_1000, 1'b0, 32'h0);
    tick();
    checks++; if (penable !== 1'b1 || psel !== 4'b0010) begin errors++; $display("FAIL rma_access: got pen=%b psel=%b want 1/0010", penable, psel); end
    hreset = 1'b1;
    tick();
    checks++; if ({psel, penable, hgrantb, hready_out} !== 7'b0) begin errors++; $display("FAIL rma_reset: got %b want 0000000", {psel, penable, hgrantb, hready_out}); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rma_hrdata: got %h want 0", hrdata); end
    hreset = 1'b0; hreqb = 1'b0;
    tick();
    checks++; if (hgrantb !== 1'b0 || psel !== 4'b0) begin errors++; $display("FAIL rma_idle: got gnt=%b psel=%b want 0/0000", hgrantb, psel); end
  endtask

`ifdef PTIMEOUT_EN
  task automatic test_timeout();
    hreqb = 1'b1; pready = '0;
    tick();
    start_xfer(32'h0000_2000, 1'b1, 32'h5);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (penable !== 1'b1) begin errors++; $display("FAIL tmo_wait%0d: got %b want 1", i, penable); end
    end
    tick();
    checks++; if (psel !== 4'b0 || hresp !== 1'b1 || hready_out !== 1'b0) begin errors++; $display("FAIL tmo_err1: got psel=%b resp=%b rdy=%b want 0000/1/0", psel, hresp, hready_out); end
    tick();
    checks++; if (hresp !== 1'b1 || hready_out !== 1'b1) begin errors++; $display("FAIL tmo_err2: got resp=%b rdy=%b want 1/1", hresp, hready_out); end
    hreqb = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_slave_error();
    test_back_to_back();
    test_grant_hold();
    test_reset_mid_access();
`ifdef PTIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
